airlock_sequencer: RTL and testbench
====================================

# airlock_sequencer

Sequences the airlock chamber between cabin pressure and water pressure. It owns the fill and drain pumps and interlocks the inner and outer doors. The operator cycle key and the `limit` flag from `limit_pressure` drive it; it sits between the operator input logic and the pump and door actuator drivers. Each transfer is timed by an internal counter. A beyond-limit condition pauses the transfer and raises an alarm.

## Interface
- `PRESS_CYCLES`, 8: cycles spent in FILL when not paused. Legal range is 2..2^CW.
- `DRAIN_CYCLES`, 12: cycles spent in DRAIN when not paused. Legal range is 2..2^CW.
- `CW`, 5: width of the transfer counter.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low. Low forces the reset state immediately.
- `cycle_req` input 1: operator cycle key. Only its rising edge is used.
- `inner_req` input 1: level request to open the inner (cabin-side) door.
- `outer_req` input 1: level request to open the outer (water-side) door.
- `limit` input 1: from `limit_pressure`. 1 means beyond the pressure limit.
- `inner_open` output 1: registered inner-door open command.
- `outer_open` output 1: registered outer-door open command.
- `pump_in` output 1: flood/pressurize pump enable.
- `pump_out` output 1: drain/evacuate pump enable.
- `busy` output 1: high in FILL or DRAIN.
- `alarm` output 1: transfer paused by `limit`.
- `done` output 1: one-cycle pulse when a transfer completes.
- `state` output 2: current state. 00 = IN, 01 = FILL, 10 = OUT, 11 = DRAIN.

## Operation
- Reset state:
  - state IN.
  - Counter 0.
  - Edge-detect register 0.
  - `inner_open`, `outer_open` and `done` all 0.
  - Combinational outputs therefore also 0.
- Edge detect: `cyc_edge = cycle_req & ~cyc_q`, where `cyc_q` registers `cycle_req` every cycle in every state.
- IN (chamber at cabin pressure):
  - `inner_open` next = `inner_req`.
  - `outer_open` next = 0.
  - Go to FILL on `cyc_edge` only if `inner_open`=0 and `inner_req`=0 that cycle. Counter loads 0.
  - If `cyc_edge` and `inner_req` occur together, the door wins and the edge is discarded, not queued.
- FILL:
  - If `limit`=0: counter increments; when counter = PRESS_CYCLES-1, go to OUT.
  - If `limit`=1: counter holds and the state holds.
  - Both doors held closed.
- OUT (chamber at water pressure): mirror of IN.
  - `outer_open` next = `outer_req`.
  - `inner_open` next = 0.
  - Go to DRAIN on `cyc_edge` with `outer_open`=0 and `outer_req`=0. Counter loads 0.
- DRAIN: as FILL, using DRAIN_CYCLES, and ends in IN.
- Combinational outputs:
  - `pump_in` = FILL & ~`limit`.
  - `pump_out` = DRAIN & ~`limit`.
  - `alarm` = (FILL|DRAIN) & `limit`.
  - `busy` = FILL|DRAIN.
- `done` is registered, 1 for exactly the first cycle in OUT after FILL and the first cycle in IN after DRAIN.
- `cyc_edge` during FILL or DRAIN is ignored.
- Door requests during FILL or DRAIN are ignored and both door outputs are forced 0.
- `limit` in IN or OUT has no effect.
- Never allowed: both doors open; any door open while either pump is enabled.
- Counter arithmetic is unsigned CW-bit. The compare is on exact equality, so the counter never wraps in legal configurations.

## Timing
- `cyc_edge` sampled at edge k (IN, doors closed):
  - state = FILL and `pump_in` = 1 from edge k.
  - With `limit` held 0, state = OUT at edge k+PRESS_CYCLES.
  - `done` = 1 during cycle k+PRESS_CYCLES .. k+PRESS_CYCLES+1.
- Each cycle with `limit`=1 in FILL or DRAIN extends the transfer by exactly one cycle.
- Door latency: `inner_req`/`outer_req` rising at edge j gives the open output at edge j. The output drops at the edge that samples the request low.
- Earliest next transfer: one cycle after the door output is seen low with its request low.
- Reset mid-transfer: state returns to IN asynchronously and pumps drop immediately. A transfer is never resumed after reset.

## Test plan
- Reset, then pulse `cycle_req` for 1 cycle with `limit`=0. Required: FILL for exactly 8 cycles with `pump_in`=1, then state 10 with a single `done` pulse.
- From OUT, pulse `cycle_req` with `limit`=1 for 3 cycles mid-drain. Required: DRAIN lasts 15 cycles; `pump_out`=0 and `alarm`=1 during exactly those 3 cycles; ends in IN.
- In IN, hold `inner_req`=1 and pulse `cycle_req` in the same cycle. Required: `inner_open`=1, no FILL, and the edge is discarded after `inner_req` drops.
- Hold `cycle_req` high across a full transfer. Required: exactly one FILL; no DRAIN starts until `cycle_req` is released and re-asserted.
- Assert `outer_req` during FILL. Required: `outer_open` stays 0 throughout FILL and rises the cycle after OUT is reached (if `outer_req` is still high).
- Drop `reset` low at cycle 4 of FILL. Required: state 00 with all outputs 0 immediately. After release, the next `cycle_req` gives a full 8-cycle FILL.

Source files
------------

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: moves the chamber between cabin and water
// pressure with timed pump transfers and interlocked inner/outer doors.
module airlock_sequencer #(
    parameter int PRESS_CYCLES = 8,
    parameter int DRAIN_CYCLES = 12,
    parameter int CW           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cycle_req,
    input  logic       inner_req,
    input  logic       outer_req,
    input  logic       limit,
    output logic       inner_open,
    output logic       outer_open,
    output logic       pump_in,
    output logic       pump_out,
    output logic       busy,
    output logic       alarm,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IN    = 2'b00,
        S_FILL  = 2'b01,
        S_OUT   = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    state_t        st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          cyc_q;
    logic          cyc_edge;
    logic          inner_nx, outer_nx, done_nx;

    assign cyc_edge = cycle_req & ~cyc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= S_IN;
            cnt        <= '0;
            cyc_q      <= 1'b0;
            inner_open <= 1'b0;
            outer_open <= 1'b0;
            done       <= 1'b0;
        end else begin
            st         <= st_nx;
            cnt        <= cnt_nx;
            cyc_q      <= cycle_req;
            inner_open <= inner_nx;
            outer_open <= outer_nx;
            done       <= done_nx;
        end
    end

    // Doors default closed; only the resting states may open their own side.
    always_comb begin
        st_nx    = st;
        cnt_nx   = cnt;
        inner_nx = 1'b0;
        outer_nx = 1'b0;
        done_nx  = 1'b0;
        case (st)
            S_IN: begin
                inner_nx = inner_req;
                if (cyc_edge && !inner_open && !inner_req) begin
                    st_nx  = S_FILL;
                    cnt_nx = '0;
                end
            end
            S_FILL: begin
                if (!limit) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == PRESS_LAST) begin
                        st_nx   = S_OUT;
                        done_nx = 1'b1;
                    end
                end
            end
            S_OUT: begin
                outer_nx = outer_req;
                if (cyc_edge && !outer_open && !outer_req) begin
                    st_nx  = S_DRAIN;
                    cnt_nx = '0;
                end
            end
            S_DRAIN: begin
                if (!limit) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == DRAIN_LAST) begin
                        st_nx   = S_IN;
                        done_nx = 1'b1;
                    end
                end
            end
            default: st_nx = S_IN;
        endcase
    end

    // Pumps are gated by limit combinationally so a pause stops them at once.
    assign pump_in  = (st == S_FILL)  & ~limit;
    assign pump_out = (st == S_DRAIN) & ~limit;
    assign busy     = (st == S_FILL) | (st == S_DRAIN);
    assign alarm    = busy & limit;
    assign state    = st;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed vector bench for airlock_sequencer: table of per-cycle inputs
// and expected outputs, plus a hand-built asynchronous reset sequence.
module tb_airlock_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cycle_req, inner_req, outer_req, limit;
    logic       inner_open, outer_open, pump_in, pump_out, busy, alarm, done;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    airlock_sequencer #(.PRESS_CYCLES(8), .DRAIN_CYCLES(12), .CW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .cycle_req (cycle_req),
        .inner_req (inner_req),
        .outer_req (outer_req),
        .limit     (limit),
        .inner_open(inner_open),
        .outer_open(outer_open),
        .pump_in   (pump_in),
        .pump_out  (pump_out),
        .busy      (busy),
        .alarm     (alarm),
        .done      (done),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Expected output word: {state[1:0], inner_open, outer_open, pump_in, pump_out, busy, alarm, done}
    localparam logic [8:0] E_IN        = 9'b00_0000000;
    localparam logic [8:0] E_IN_DONE   = 9'b00_0000001;
    localparam logic [8:0] E_IN_INNER  = 9'b00_1000000;
    localparam logic [8:0] E_FILL_RUN  = 9'b01_0010100;
    localparam logic [8:0] E_OUT       = 9'b10_0000000;
    localparam logic [8:0] E_OUT_DONE  = 9'b10_0000001;
    localparam logic [8:0] E_OUT_OUTER = 9'b10_0100000;
    localparam logic [8:0] E_DRN_RUN   = 9'b11_0001100;
    localparam logic [8:0] E_DRN_PAUSE = 9'b11_0000110;

    typedef struct packed {
        logic       cyc;
        logic       inr;
        logic       outr;
        logic       lim;
        logic [8:0] exp;
    } vec_t;

    vec_t q[$];

    function automatic logic [8:0] observed();
        return {state, inner_open, outer_open, pump_in, pump_out, busy, alarm, done};
    endfunction

    task automatic push(input int n, input logic c, input logic i, input logic o,
                        input logic l, input logic [8:0] e);
        vec_t v;
        v.cyc = c; v.inr = i; v.outr = o; v.lim = l; v.exp = e;
        for (int k = 0; k < n; k++) q.push_back(v);
    endtask

    task automatic check(input string tag, input int idx, input logic [8:0] exp);
        logic [8:0] got;
        got = observed();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %b, required %b", tag, idx, got, exp);
        end
    endtask

    task automatic run_queue(input string tag);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            cycle_req = q[k].cyc;
            inner_req = q[k].inr;
            outer_req = q[k].outr;
            limit     = q[k].lim;
            #1;
            check(tag, k, q[k].exp);
        end
        q.delete();
    endtask

    initial begin
        reset = 1'b1;
        cycle_req = 1'b0; inner_req = 1'b0; outer_req = 1'b0; limit = 1'b0;
        #3 reset = 1'b0;
        #1 check("reset_state", 0, E_IN);
        repeat (2) @(negedge clk);
        #1 check("reset_state", 1, E_IN);
        reset = 1'b1;

        // Plain fill: 8 FILL cycles then OUT with one done pulse
        push(1, 1, 0, 0, 0, E_IN);
        push(8, 0, 0, 0, 0, E_FILL_RUN);
        push(1, 0, 0, 0, 0, E_OUT_DONE);
        push(1, 0, 0, 0, 0, E_OUT);
        // Drain with a 3-cycle limit pause: 15 DRAIN cycles total
        push(1, 1, 0, 0, 0, E_OUT);
        push(5, 0, 0, 0, 0, E_DRN_RUN);
        push(3, 0, 0, 0, 1, E_DRN_PAUSE);
        push(7, 0, 0, 0, 0, E_DRN_RUN);
        push(1, 0, 0, 0, 0, E_IN_DONE);
        push(1, 0, 0, 0, 0, E_IN);
        // Door request coincident with cycle edge: door wins, edge dropped
        push(1, 1, 1, 0, 0, E_IN);
        push(1, 1, 1, 0, 0, E_IN_INNER);
        push(1, 1, 0, 0, 0, E_IN_INNER);
        push(1, 1, 0, 0, 0, E_IN);
        push(1, 0, 0, 0, 0, E_IN);
        // cycle_req held high: one FILL only, DRAIN waits for a fresh edge
        push(1, 1, 0, 0, 0, E_IN);
        push(8, 1, 0, 0, 0, E_FILL_RUN);
        push(1, 1, 0, 0, 0, E_OUT_DONE);
        push(2, 1, 0, 0, 0, E_OUT);
        push(1, 0, 0, 0, 0, E_OUT);
        push(1, 1, 0, 0, 0, E_OUT);
        push(12, 1, 0, 0, 0, E_DRN_RUN);
        push(1, 0, 0, 0, 0, E_IN_DONE);
        push(1, 0, 0, 0, 1, E_IN);
        // outer_req during FILL is ignored, honoured once in OUT
        push(1, 1, 0, 0, 0, E_IN);
        push(8, 0, 0, 1, 0, E_FILL_RUN);
        push(1, 0, 0, 1, 0, E_OUT_DONE);
        push(1, 0, 0, 1, 1, E_OUT_OUTER);
        push(1, 1, 0, 1, 0, E_OUT_OUTER);
        push(1, 1, 0, 0, 0, E_OUT_OUTER);
        push(1, 0, 0, 0, 0, E_OUT);
        push(1, 1, 0, 0, 0, E_OUT);
        push(12, 0, 0, 0, 0, E_DRN_RUN);
        push(1, 0, 0, 0, 0, E_IN_DONE);
        run_queue("table");

        // Reset dropped mid-cycle during the 4th FILL cycle
        push(1, 1, 0, 0, 0, E_IN);
        push(4, 0, 0, 0, 0, E_FILL_RUN);
        run_queue("pre_reset");
        #2 reset = 1'b0;
        #1 check("reset_async", 0, E_IN);
        repeat (2) @(negedge clk);
        #1 check("reset_hold", 0, E_IN);
        reset = 1'b1;
        push(2, 0, 0, 0, 0, E_IN);
        push(1, 1, 0, 0, 0, E_IN);
        push(8, 0, 0, 0, 0, E_FILL_RUN);
        push(1, 0, 0, 0, 0, E_OUT_DONE);
        push(1, 0, 0, 0, 0, E_OUT);
        run_queue("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
